// File: rtl/mmcm_lock_supervisor.sv
// MMCM reset/lock supervisor: timed reset pulse, lock wait with timeout and bounded retries,
// settle qualification, stable flag. Optional lock-loss counter: define MMCM_SUP_LOCK_LOSS_CNT_EN.
module mmcm_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int SETTLE_CYCLES       = 256,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       CLK_33MHz,
    input  logic       RESET_H,
    input  logic       MMCM_LOCKED_H,
    input  logic       RESTART_REQ_H,
    output logic       MMCM_RST_H,
    output logic       CLOCKS_STABLE_H,
    output logic       CLOCK_FAULT_H,
    output logic [3:0] RETRY_COUNT,
    output logic [2:0] STATE,
    output logic [7:0] LOCK_LOSS_COUNT
);

    typedef enum logic [2:0] {
        S_ASSERT_RST = 3'd1,
        S_WAIT_LOCK  = 3'd2,
        S_SETTLE     = 3'd3,
        S_STABLE     = 3'd4,
        S_FAULT      = 3'd5
    } state_t;

    // One shared timer serves the pulse, timeout and settle phases, so size it for the longest.
    localparam int TMAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES
                                                                     : LOCK_TIMEOUT_CYCLES;
    localparam int TMAX   = (TMAX_A > SETTLE_CYCLES) ? TMAX_A : SETTLE_CYCLES;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [TW-1:0] PULSE_LAST   = TW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      retry_q, retry_d;
    logic            lock_meta, lock_sync;
    logic            attempt_failed;

    // Two-flop synchronizer for the asynchronous LOCKED pin.
    always_ff @(posedge CLK_33MHz) begin
        if (RESET_H) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep this a true two-stage shift; blocking ones would collapse it to one flop.
            lock_meta <= MMCM_LOCKED_H;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge CLK_33MHz) begin
        if (RESET_H) begin
            state_q <= S_ASSERT_RST;
            timer_q <= '0;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_d        = state_q;
        timer_d        = timer_q;
        retry_d        = retry_q;
        attempt_failed = 1'b0;

        if (RESTART_REQ_H) begin
            state_d = S_ASSERT_RST;
            timer_d = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                S_ASSERT_RST: begin
                    if (timer_q == PULSE_LAST) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock is checked before the timeout so a coincident lock still counts.
                    if (lock_sync) begin
                        state_d = S_SETTLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        attempt_failed = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_SETTLE: begin
                    if (!lock_sync) begin
                        attempt_failed = 1'b1;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_d = S_STABLE;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_STABLE: begin
                    if (!lock_sync) begin
                        state_d = S_ASSERT_RST;
                        timer_d = '0;
                        retry_d = '0;
                    end
                end
                S_FAULT: begin
                    timer_d = '0;
                end
                default: begin
                    state_d = S_ASSERT_RST;
                    timer_d = '0;
                end
            endcase

            if (attempt_failed) begin
                timer_d = '0;
                if (retry_q == RETRY_LIMIT) begin
                    state_d = S_FAULT;
                end else begin
                    state_d = S_ASSERT_RST;
                    retry_d = retry_q + 4'd1;
                end
            end
        end
    end

    // Flags are decoded from the next state so they move on the same edge as STATE.
    always_ff @(posedge CLK_33MHz) begin
        if (RESET_H) begin
            MMCM_RST_H      <= 1'b1;
            CLOCKS_STABLE_H <= 1'b0;
            CLOCK_FAULT_H   <= 1'b0;
        end else begin
            MMCM_RST_H      <= (state_d == S_ASSERT_RST) || (state_d == S_FAULT);
            CLOCKS_STABLE_H <= (state_d == S_STABLE);
            CLOCK_FAULT_H   <= (state_d == S_FAULT);
        end
    end

    assign STATE       = state_q;
    assign RETRY_COUNT = retry_q;

`ifdef MMCM_SUP_LOCK_LOSS_CNT_EN
    logic       loss_event;
    logic [7:0] loss_count_q;

    // A restart request coincident with lock loss is a deliberate restart, not a loss event.
    assign loss_event = (state_q == S_STABLE) && !lock_sync && !RESTART_REQ_H;

    always_ff @(posedge CLK_33MHz) begin
        if (RESET_H) begin
            loss_count_q <= 8'd0;
        end else if (loss_event && (loss_count_q != 8'hFF)) begin
            loss_count_q <= loss_count_q + 8'd1;
        end
    end

    assign LOCK_LOSS_COUNT = loss_count_q;
`else
    assign LOCK_LOSS_COUNT = 8'd0;
`endif

endmodule

// File: doc/mmcm_lock_supervisor.md
# mmcm_lock_supervisor

Sequences reset and lock qualification for the clock-domain MMCM: issues a timed MMCM reset pulse, waits for LOCKED with a timeout, retries a bounded number of times, qualifies lock over a settle window, then asserts CLOCKS_STABLE_H. It runs on the 33 MHz reference clock, drives the MMCM RST pin, and supplies the stability flag that downstream per-domain reset logic re-synchronizes. Lock loss while stable drops the flag and restarts the sequence automatically.

## Interface
- RST_PULSE_CYCLES, 8: cycles MMCM_RST_H is held high per attempt (≥1).
- LOCK_TIMEOUT_CYCLES, 4096: WAIT_LOCK cycles before an attempt is declared failed (≥2).
- SETTLE_CYCLES, 256: consecutive synchronized-lock cycles required before stable (≥1).
- MAX_RETRIES, 3: failed attempts tolerated after the first before FAULT (0–15).

- CLK_33MHz  in  1  reference clock; all logic in this domain.
- RESET_H  in  1  synchronous, active-high reset.
- MMCM_LOCKED_H  in  1  MMCM LOCKED, asynchronous; 2-flop synchronized internally.
- RESTART_REQ_H  in  1  single-cycle request to re-run the full sequence.
- MMCM_RST_H  out  1  registered MMCM reset.
- CLOCKS_STABLE_H  out  1  registered; high only in STABLE.
- CLOCK_FAULT_H  out  1  registered; high only in FAULT.
- RETRY_COUNT  out  4  failed attempts in current sequence.
- STATE  out  3  current state code.
- LOCK_LOSS_COUNT  out  8  lock-loss events while STABLE (see Configuration).

## Operation
- States/codes: ASSERT_RST=1, WAIT_LOCK=2, SETTLE=3, STABLE=4, FAULT=5. Codes 0,6,7 unreachable; if entered, next state ASSERT_RST.
- Reset values (held while RESET_H=1): STATE=ASSERT_RST, timer=0, MMCM_RST_H=1, CLOCKS_STABLE_H=0, CLOCK_FAULT_H=0, RETRY_COUNT=0, LOCK_LOSS_COUNT=0, sync flops=0.
- ASSERT_RST: MMCM_RST_H=1; timer counts 0..RST_PULSE_CYCLES-1, then → WAIT_LOCK, timer=0.
- WAIT_LOCK: MMCM_RST_H=0. locked_sync=1 → SETTLE, timer=0. Else at timer=LOCK_TIMEOUT_CYCLES-1: attempt failed. Lock and timeout same cycle: lock wins.
- Failed attempt: if RETRY_COUNT==MAX_RETRIES → FAULT; else RETRY_COUNT+1, → ASSERT_RST, timer=0.
- SETTLE: locked_sync=0 on any cycle → failed attempt (same rule). After SETTLE_CYCLES consecutive locked cycles → STABLE, RETRY_COUNT=0.
- STABLE: CLOCKS_STABLE_H=1. locked_sync=0 → ASSERT_RST, RETRY_COUNT=0, LOCK_LOSS_COUNT+1 (saturates at 255).
- FAULT: MMCM_RST_H=1 (MMCM held in reset), CLOCK_FAULT_H=1; left only via RESTART_REQ_H or RESET_H.
- RESTART_REQ_H=1 in any state: → ASSERT_RST, timer=0, RETRY_COUNT=0; highest priority after RESET_H. Coincident with lock loss in STABLE: LOCK_LOSS_COUNT not incremented. In ASSERT_RST it restarts the pulse timer.
- Outputs decoded from next state and registered: they change on the same edge as STATE.

## Timing
- MMCM_LOCKED_H rise → STATE=SETTLE on 3rd rising edge (2 sync + 1 decision).
- SETTLE entry → CLOCKS_STABLE_H=1 exactly SETTLE_CYCLES edges later if lock holds.
- MMCM_LOCKED_H fall in STABLE → CLOCKS_STABLE_H=0 and MMCM_RST_H=1 on 3rd edge.
- RESET_H release → MMCM_RST_H high for RST_PULSE_CYCLES edges, then low.
- Timeout attempt length: RST_PULSE_CYCLES + LOCK_TIMEOUT_CYCLES cycles.
- Lock glitches shorter than one CLK_33MHz period may be missed; not required to detect.

## Configuration
- MMCM_SUP_LOCK_LOSS_CNT_EN defined: 8-bit saturating LOCK_LOSS_COUNT implemented as above, cleared only by RESET_H.
- Undefined: counter not built; LOCK_LOSS_COUNT tied to 8'd0. All other behaviour identical.

## Test plan
Parameters RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, SETTLE_CYCLES=8, MAX_RETRIES=2.
- Normal bring-up: release RESET_H, raise LOCKED 10 cycles later → MMCM_RST_H high 4 cycles, SETTLE 3 edges after LOCKED, CLOCKS_STABLE_H=1 8 edges later, RETRY_COUNT=0.
- Never lock → three attempts of 36 cycles, RETRY_COUNT 0→1→2, then STATE=5, CLOCK_FAULT_H=1, MMCM_RST_H=1 held.
- Lock drops on 5th SETTLE cycle → RETRY_COUNT=1, STATE=ASSERT_RST; re-lock held → STABLE, RETRY_COUNT=0.
- Lock loss in STABLE → CLOCKS_STABLE_H=0 on 3rd edge, LOCK_LOSS_COUNT=1 (macro defined) / 0 (undefined); re-lock → stable again.
- RESTART_REQ_H pulse in FAULT → STATE=ASSERT_RST, CLOCK_FAULT_H=0, RETRY_COUNT=0; RESTART_REQ_H coincident with lock loss → LOCK_LOSS_COUNT unchanged.
- RESET_H asserted mid-SETTLE → next edge all outputs at reset values, STATE=1.
